multi_cycle_ctrl: RTL

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/ctrl_pkg.sv | 212 +++++++++++++++++++++
 rtl/mem_wait_timer.sv | 50 +++++
 rtl/multi_cycle_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared definitions for the multi-cycle datapath controller.
// Holds opcode constants, the FSM state encoding, ALU operation codes,
// datapath mux-select encodings, the registered control-word struct and the
// helper functions that map a state (plus latched opcode) to a control word.
// Configuration: the controller honours macro EXT_BRANCH_EN; this package is
// macro independent.
package ctrl_pkg;

    // Instruction opcodes (MIPS-style primary opcode field)
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BGEZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNEZ  = 6'b000101;
    localparam logic [5:0] OP_BGT   = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALU operation codes (3 significant bits; wider alu_op_o is zero padded)
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_OR    = 3'd2;
    localparam logic [2:0] ALU_RTYPE = 3'd3;

    // Mux-select encodings
    localparam logic       IORD_PC      = 1'b0;
    localparam logic       IORD_ALUOUT  = 1'b1;
    localparam logic       SRCA_PC      = 1'b0;
    localparam logic       SRCA_RS      = 1'b1;
    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;
    localparam logic [1:0] DST_RT       = 2'd0;
    localparam logic [1:0] DST_RD       = 2'd1;
    localparam logic [1:0] DST_R31      = 2'd2;
    localparam logic [1:0] WB_ALUOUT    = 2'd0;
    localparam logic [1:0] WB_MDR       = 2'd1;
    localparam logic [1:0] WB_PC        = 2'd2;
    localparam logic [1:0] WB_LUI       = 2'd3;
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] BR_EQ        = 2'd0;
    localparam logic [1:0] BR_NE        = 2'd1;
    localparam logic [1:0] BR_GT        = 2'd2;
    localparam logic [1:0] BR_GEZ       = 2'd3;

    // FSM state encoding (visible on state_o)
    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWR  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_IEXEC  = 4'd8,
        ST_IWB    = 4'd9,
        ST_BRANCH = 4'd10,
        ST_JUMP   = 4'd11,
        ST_JAL    = 4'd12,
        ST_TRAP   = 4'd13
    } state_e;

    // Registered control word. fetch_en marks FETCH; the IR/PC load strobes
    // are fetch_en qualified by mem_ready_i in the top.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       i_or_d;
        logic       fetch_en;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic [1:0] branch_type;
        logic       sign_ext;
        logic       trap;
    } ctrl_t;

    // True for states that issue a memory request and wait for mem_ready_i
    function automatic logic is_mem_state(input state_e s);
        logic r;
        case (s)
            ST_FETCH, ST_MEMRD, ST_MEMWR: r = 1'b1;
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

    // Branch condition selected by the branch opcode
    function automatic logic [1:0] branch_type_of(input logic [5:0] op);
        logic [1:0] r;
        case (op)
            OP_BNEZ: r = BR_NE;
            OP_BGT:  r = BR_GT;
            OP_BGEZ: r = BR_GEZ;
            default: r = BR_EQ;
        endcase
        return r;
    endfunction

    // Moore output decode: control word for a state and its latched opcode
    function automatic ctrl_t decode_ctrl(input state_e s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_req   = 1'b1;
                c.i_or_d    = IORD_PC;
                c.fetch_en  = 1'b1;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
            end
            ST_DECODE: begin
                // branch target = PC+4 + (imm<<2), precomputed into ALUOut
                c.alu_src_b = SRCB_IMM_SH2;
                c.alu_op    = ALU_ADD;
                c.sign_ext  = 1'b1;
            end
            ST_MEMADR: begin
                c.alu_src_a = SRCA_RS;
                c.alu_src_b = SRCB_IMM;
                c.sign_ext  = 1'b1;
                c.alu_op    = ALU_ADD;
            end
            ST_MEMRD: begin
                c.mem_req = 1'b1;
                c.i_or_d  = IORD_ALUOUT;
            end
            ST_MEMWR: begin
                c.mem_req   = 1'b1;
                c.i_or_d    = IORD_ALUOUT;
                c.mem_write = 1'b1;
            end
            ST_MEMWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = DST_RT;
                c.mem_to_reg = WB_MDR;
            end
            ST_EXEC: begin
                c.alu_src_a = SRCA_RS;
                c.alu_src_b = SRCB_RT;
                c.alu_op    = ALU_RTYPE;
            end
            ST_ALUWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = DST_RD;
                c.mem_to_reg = WB_ALUOUT;
            end
            ST_IEXEC: begin
                c.alu_src_a = SRCA_RS;
                c.alu_src_b = SRCB_IMM;
                if (op == OP_ORI) begin
                    c.alu_op   = ALU_OR;
                    c.sign_ext = 1'b0;
                end else if (op == OP_ADDI) begin
                    c.alu_op   = ALU_ADD;
                    c.sign_ext = 1'b1;
                end else begin
                    // LUI: result comes from the imm<<16 write-back path
                    c.alu_op   = ALU_ADD;
                    c.sign_ext = 1'b0;
                end
            end
            ST_IWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = DST_RT;
                c.mem_to_reg = (op == OP_LUI) ? WB_LUI : WB_ALUOUT;
            end
            ST_BRANCH: begin
                c.alu_src_a     = SRCA_RS;
                c.alu_src_b     = SRCB_RT;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
                c.branch_type   = branch_type_of(op);
            end
            ST_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            ST_JAL: begin
                c.pc_write   = 1'b1;
                c.pc_source  = PCSRC_JUMP;
                c.reg_write  = 1'b1;
                c.reg_dst    = DST_R31;
                c.mem_to_reg = WB_PC;
            end
            ST_TRAP: begin
                c.trap = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer -- counts cycles spent waiting for mem_ready_i in a memory
// state and flags a timeout on the MEM_TIMEOUT-th consecutive not-ready cycle.
// A ready on that same cycle wins (no timeout).
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset (clears the count)
//   clear_i    entering a memory state: restart the count from zero
//   active_i   FSM is currently in a memory state
//   ready_i    memory completes this cycle
//   timeout_o  this cycle is the last allowed wait and memory is not ready
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic active_i,
    input  logic ready_i,
    output logic timeout_o
);

    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] count_d;
    logic [7:0] count_q;

    // Next count: restart on entry, advance on every not-ready waiting cycle
    always_comb begin
        if (clear_i) begin
            count_d = 8'd0;
        end else if (active_i && !ready_i) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the number of not-ready cycles already seen in this state
    assign timeout_o = active_i & ~ready_i & (count_q == LAST_WAIT);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl -- Moore FSM controller for a multi-cycle MIPS-style
// datapath. Control outputs are registered: the next state's control word is
// decoded and captured together with the state, so every output is a function
// of the current state and latched opcode. The exception is the IR/PC load
// strobe in FETCH, which is qualified by mem_ready_i in the same cycle.
// Configuration macro: EXT_BRANCH_EN enables BNEZ, BGT, BGEZ, LUI and JAL;
// without it those opcodes trap and branch_type_o is constant 0.
// Ports:
//   clk_i, rst_i (sync, active-high), instr_op_i (IR opcode), mem_ready_i
//   mem_req_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o, pc_write_cond_o
//   reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o
//   pc_source_o, branch_type_o, sign_ext_o, trap_o (sticky), state_o
module multi_cycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [5:0]          instr_op_i,
    input  logic                mem_ready_i,
    output logic                mem_req_o,
    output logic                mem_write_o,
    output logic                i_or_d_o,
    output logic                ir_write_o,
    output logic                pc_write_o,
    output logic                pc_write_cond_o,
    output logic                reg_write_o,
    output logic [1:0]          reg_dst_o,
    output logic [1:0]          mem_to_reg_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [1:0]          pc_source_o,
    output logic [1:0]          branch_type_o,
    output logic                sign_ext_o,
    output logic                trap_o,
    output logic [3:0]          state_o
);

    state_e     state_d;
    state_e     state_q;
    logic [5:0] op_d;
    logic [5:0] op_q;
    ctrl_t      ctrl_raw_s;
    ctrl_t      ctrl_d;
    ctrl_t      ctrl_q;
    logic       timeout_s;
    logic       mem_active_s;
    logic       mem_entry_s;

    // Opcode dispatch out of DECODE
    function automatic state_e decode_next(input logic [5:0] op);
        state_e r;
        case (op)
            OP_RTYPE:        r = ST_EXEC;
            OP_LW, OP_SW:    r = ST_MEMADR;
            OP_BEQ:          r = ST_BRANCH;
            OP_J:            r = ST_JUMP;
            OP_ADDI, OP_ORI: r = ST_IEXEC;
`ifdef EXT_BRANCH_EN
            OP_BNEZ, OP_BGT, OP_BGEZ: r = ST_BRANCH;
            OP_JAL:                   r = ST_JAL;
            OP_LUI:                   r = ST_IEXEC;
`endif
            default:         r = ST_TRAP;
        endcase
        return r;
    endfunction

    assign mem_active_s = is_mem_state(state_q);
    // A new memory state is being entered (MEMWR->FETCH included)
    assign mem_entry_s  = is_mem_state(state_d) && (state_d != state_q);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (mem_entry_s),
        .active_i (mem_active_s),
        .ready_i  (mem_ready_i),
        .timeout_o(timeout_s)
    );

    // Next state, opcode latch and next-state control word
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready_i) begin
                    state_d = ST_DECODE;
                end else if (timeout_s) begin
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                // IR is valid from DECODE on; keep the opcode for later states
                op_d    = instr_op_i;
                state_d = decode_next(instr_op_i);
            end
            ST_MEMADR: begin
                state_d = (op_q == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                if (mem_ready_i) begin
                    state_d = ST_MEMWB;
                end else if (timeout_s) begin
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_MEMRD;
                end
            end
            ST_MEMWR: begin
                if (mem_ready_i) begin
                    state_d = ST_FETCH;
                end else if (timeout_s) begin
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_MEMWR;
                end
            end
            ST_EXEC:  state_d = ST_ALUWB;
            ST_IEXEC: state_d = ST_IWB;
            ST_MEMWB, ST_ALUWB, ST_IWB, ST_BRANCH, ST_JUMP, ST_JAL: begin
                state_d = ST_FETCH;
            end
            ST_TRAP:  state_d = ST_TRAP;
            default:  state_d = ST_TRAP;
        endcase

        ctrl_raw_s = decode_ctrl(state_d, op_d);
`ifdef EXT_BRANCH_EN
        ctrl_d = ctrl_raw_s;
`else
        ctrl_d             = ctrl_raw_s;
        ctrl_d.branch_type = BR_EQ;
`endif
    end

    // State, opcode and registered control word
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_FETCH;
            op_q    <= 6'd0;
            ctrl_q  <= decode_ctrl(ST_FETCH, 6'd0);
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign mem_req_o       = ctrl_q.mem_req;
    assign mem_write_o     = ctrl_q.mem_write;
    assign i_or_d_o        = ctrl_q.i_or_d;
    assign ir_write_o      = ctrl_q.fetch_en & mem_ready_i;
    assign pc_write_o      = ctrl_q.pc_write | (ctrl_q.fetch_en & mem_ready_i);
    assign pc_write_cond_o = ctrl_q.pc_write_cond;
    assign reg_write_o     = ctrl_q.reg_write;
    assign reg_dst_o       = ctrl_q.reg_dst;
    assign mem_to_reg_o    = ctrl_q.mem_to_reg;
    assign alu_src_a_o     = ctrl_q.alu_src_a;
    assign alu_src_b_o     = ctrl_q.alu_src_b;
    assign alu_op_o        = ALU_OP_W'(ctrl_q.alu_op);
    assign pc_source_o     = ctrl_q.pc_source;
    assign branch_type_o   = ctrl_q.branch_type;
    assign sign_ext_o      = ctrl_q.sign_ext;
    assign trap_o          = ctrl_q.trap;
    assign state_o         = state_q;

endmodule
